// File: rtl/bp_clint_responder.sv
// bp_clint_responder: single-core CLINT device behind an uncached load/store port.
//
// Registers (decoded on cmd_addr_i[31:0], upper address bits ignored):
//   0x0200_0000         msip     (bit 0 only, other bits read 0)
//   0x0200_4000/_4004   mtimecmp (64-bit, 32-bit halves addressable)
//   0x0200_bff8/_bffc   mtime    (64-bit, 32-bit halves addressable)
// Size 3 accesses all 64 bits (needs addr[2:0] = 0), size 2 accesses the half
// selected by addr[2]. Sizes 0/1 and unmapped offsets return err with no state change.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   cmd_v_i / cmd_ready_o     command handshake (one outstanding command)
//   cmd_w_i, cmd_addr_i,
//   cmd_size_i, cmd_data_i    command fields, store data right-aligned
//   resp_v_o / resp_yumi_i    response handshake, response held until yumi
//   resp_data_o, resp_err_o   load data (0 for stores), access fault flag
//   software_irq_o            msip bit 0
//   timer_irq_o               registered (mtime >= mtimecmp)
//
// Optional feature: define BP_CLINT_PRESCALE_EN to advance mtime once every
// tick_div_p cycles instead of every cycle.

module bp_clint_responder #(
  parameter int unsigned paddr_width_p = 56,
  parameter int unsigned data_width_p  = 64,
  parameter int unsigned tick_div_p    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_w_i,
  input  logic [paddr_width_p-1:0] cmd_addr_i,
  input  logic [1:0]               cmd_size_i,
  input  logic [data_width_p-1:0]  cmd_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic [data_width_p-1:0]  resp_data_o,
  output logic                     resp_err_o,
  output logic                     software_irq_o,
  output logic                     timer_irq_o
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e      r_state;
  logic        r_cmd_ready;
  logic        r_resp_v;
  logic        r_resp_err;
  logic [63:0] r_resp_data;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_timer_irq;

  logic [31:0] w_addr;
  logic        w_sel_msip;
  logic        w_sel_cmp;
  logic        w_sel_time;
  logic        w_size_ok;
  logic        w_err;
  logic        w_accept;
  logic        w_wr_msip;
  logic        w_wr_cmp;
  logic        w_wr_time;
  logic        w_tick;
  logic [63:0] w_cur;
  logic [63:0] w_rdata;
  logic [63:0] w_wdata;
  logic        w_unused_addr;

  assign w_addr        = cmd_addr_i[31:0];
  assign w_unused_addr = ^cmd_addr_i[paddr_width_p-1:32];

  // Halves of mtimecmp/mtime share addr[31:3]; addr[2] picks the half.
  assign w_sel_msip = (w_addr == 32'h0200_0000);
  assign w_sel_cmp  = (w_addr[31:3] == 29'h0040_0800) && (w_addr[1:0] == 2'b00);
  assign w_sel_time = (w_addr[31:3] == 29'h0040_17ff) && (w_addr[1:0] == 2'b00);

  assign w_size_ok = (cmd_size_i == 2'd3) ? (w_addr[2:0] == 3'b000) : (cmd_size_i == 2'd2);
  assign w_err     = !(w_sel_msip || w_sel_cmp || w_sel_time) || !w_size_ok;

  assign w_accept  = cmd_v_i && r_cmd_ready;
  assign w_wr_msip = w_accept && cmd_w_i && !w_err && w_sel_msip;
  assign w_wr_cmp  = w_accept && cmd_w_i && !w_err && w_sel_cmp;
  assign w_wr_time = w_accept && cmd_w_i && !w_err && w_sel_time;

  always_comb begin
    w_cur = '0;
    if (w_sel_msip) begin
      w_cur = {63'b0, r_msip};
    end else if (w_sel_cmp) begin
      w_cur = r_mtimecmp;
    end else if (w_sel_time) begin
      w_cur = r_mtime;
    end
  end

  // Load data, zero-extended for half accesses; stores and faults return 0.
  always_comb begin
    w_rdata = '0;
    if (!w_err && !cmd_w_i) begin
      if (cmd_size_i == 2'd3) begin
        w_rdata = w_cur;
      end else if (w_addr[2]) begin
        w_rdata = {32'b0, w_cur[63:32]};
      end else begin
        w_rdata = {32'b0, w_cur[31:0]};
      end
    end
  end

  // Store data merged into the untouched half of the current register value.
  always_comb begin
    w_wdata = cmd_data_i;
    if (cmd_size_i != 2'd3) begin
      if (w_addr[2]) begin
        w_wdata = {cmd_data_i[31:0], w_cur[31:0]};
      end else begin
        w_wdata = {w_cur[63:32], cmd_data_i[31:0]};
      end
    end
  end

`ifdef BP_CLINT_PRESCALE_EN
  logic [15:0] r_presc;
  logic        w_presc_wrap;

  assign w_presc_wrap = (r_presc == 16'(tick_div_p - 1));
  assign w_tick       = w_presc_wrap;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_presc <= '0;
    end else if (w_wr_time || w_presc_wrap) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end
`else
  logic w_unused_tick_div;

  assign w_tick            = 1'b1;
  assign w_unused_tick_div = ^tick_div_p;
`endif

  // A store to mtime takes priority over the tick in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mtime <= '0;
    end else if (w_wr_time) begin
      r_mtime <= w_wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
    end else begin
      if (w_wr_cmp) begin
        r_mtimecmp <= w_wdata;
      end
      if (w_wr_msip) begin
        r_msip <= w_wdata[0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_timer_irq <= 1'b0;
    end else begin
      r_timer_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= StIdle;
      r_cmd_ready <= 1'b1;
      r_resp_v    <= 1'b0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (cmd_v_i) begin
            r_state     <= StResp;
            r_cmd_ready <= 1'b0;
            r_resp_v    <= 1'b1;
            r_resp_data <= w_rdata;
            r_resp_err  <= w_err;
          end
        end
        StResp: begin
          if (resp_yumi_i) begin
            r_state     <= StIdle;
            r_cmd_ready <= 1'b1;
            r_resp_v    <= 1'b0;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_cmd_ready <= 1'b1;
          r_resp_v    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o    = r_cmd_ready;
  assign resp_v_o       = r_resp_v;
  assign resp_data_o    = r_resp_data;
  assign resp_err_o     = r_resp_err;
  assign software_irq_o = r_msip;
  assign timer_irq_o    = r_timer_irq;

endmodule

// File: tb/tb_bp_clint_responder.sv
// Self-checking bench for bp_clint_responder. The reference model describes the
// registers as functions of the cycle number: mtime is a base value plus elapsed
// cycles (divided by the prescale ratio), changed only by stores.

module tb_bp_clint_responder;

  localparam int unsigned TickDiv = 4;
`ifdef BP_CLINT_PRESCALE_EN
  localparam longint Div = TickDiv;
`else
  localparam longint Div = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_v_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_w_i = 1'b0;
  logic [55:0] cmd_addr_i = '0;
  logic [1:0]  cmd_size_i = '0;
  logic [63:0] cmd_data_i = '0;
  logic        resp_v_o;
  logic        resp_yumi_i = 1'b0;
  logic [63:0] resp_data_o;
  logic        resp_err_o;
  logic        software_irq_o;
  logic        timer_irq_o;

  bp_clint_responder #(
    .paddr_width_p(56),
    .data_width_p (64),
    .tick_div_p   (TickDiv)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .cmd_v_i       (cmd_v_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_w_i       (cmd_w_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_size_i    (cmd_size_i),
    .cmd_data_i    (cmd_data_i),
    .resp_v_o      (resp_v_o),
    .resp_yumi_i   (resp_yumi_i),
    .resp_data_o   (resp_data_o),
    .resp_err_o    (resp_err_o),
    .software_irq_o(software_irq_o),
    .timer_irq_o   (timer_irq_o)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: current and previous segment of each register.
  logic [63:0] t_base, t_prev_base;
  longint      t_cyc, t_prev_cyc;
  logic [63:0] c_val, c_prev;
  longint      c_cyc;
  logic        m_msip;

  function automatic logic [63:0] mtime_at(input longint c);
    if (c >= t_cyc) return t_base + 64'((c - t_cyc) / Div);
    return t_prev_base + 64'((c - t_prev_cyc) / Div);
  endfunction

  function automatic logic [63:0] cmp_at(input longint c);
    if (c >= c_cyc) return c_val;
    return c_prev;
  endfunction

  function automatic logic exp_timer(input longint c);
    return mtime_at(c - 1) >= cmp_at(c - 1);
  endfunction

  task automatic model_reset(input longint c);
    t_base = '0; t_prev_base = '0; t_cyc = c; t_prev_cyc = c;
    c_val = '1; c_prev = '1; c_cyc = c;
    m_msip = 1'b0;
  endtask

  // Applies one access accepted in cycle c; returns expected data and err.
  task automatic model_access(input bit w, input logic [31:0] a, input logic [1:0] sz,
                              input logic [63:0] d, input longint c,
                              output logic [63:0] rd, output logic err);
    int          which;
    logic [63:0] cur, nv;
    which = -1;
    if (a == 32'h0200_0000) which = 0;
    else if (a == 32'h0200_4000 || a == 32'h0200_4004) which = 1;
    else if (a == 32'h0200_bff8 || a == 32'h0200_bffc) which = 2;
    err = (which < 0) || (sz < 2) || (sz == 3 && a[2:0] != 3'b000);
    rd  = '0;
    if (err) return;
    cur = (which == 0) ? {63'b0, m_msip} : (which == 1) ? cmp_at(c) : mtime_at(c);
    if (!w) begin
      rd = (sz == 3) ? cur : (a[2] ? (cur >> 32) : (cur & 64'hFFFF_FFFF));
    end else begin
      nv = (sz == 3) ? d : (a[2] ? {d[31:0], cur[31:0]} : {cur[63:32], d[31:0]});
      if (which == 0) begin
        m_msip = nv[0];
      end else if (which == 1) begin
        c_prev = cmp_at(c); c_val = nv; c_cyc = c + 1;
      end else begin
        t_prev_base = t_base; t_prev_cyc = t_cyc; t_base = nv; t_cyc = c + 1;
      end
    end
  endtask

  // Drives one command from a negedge, waits for and consumes its response.
  task automatic xact(input bit w, input logic [31:0] a, input logic [1:0] sz,
                      input logic [63:0] d, output logic [63:0] rd, output logic err,
                      output longint acc);
    int n;
    n = 0;
    while (!cmd_ready_o && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready_o) begin
      n_checks++; n_fail++;
      $display("FAIL xact_ready: cmd_ready_o=%b required 1", cmd_ready_o);
    end
    cmd_v_i = 1'b1; cmd_w_i = w; cmd_addr_i = {24'($urandom), a};
    cmd_size_i = sz; cmd_data_i = d; acc = cyc;
    @(negedge clk);
    cmd_v_i = 1'b0;
    n = 0;
    while (!resp_v_o && n < 20) begin @(negedge clk); n++; end
    if (!resp_v_o) begin
      n_checks++; n_fail++;
      $display("FAIL xact_resp: resp_v_o=%b required 1", resp_v_o);
    end
    rd = resp_data_o; err = resp_err_o;
    resp_yumi_i = 1'b1;
    @(negedge clk);
    resp_yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    logic ok;
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    model_reset(cyc);
    ok = (resp_v_o === 1'b0) && (resp_data_o === 64'h0) && (resp_err_o === 1'b0) &&
         (cmd_ready_o === 1'b1) && (software_irq_o === 1'b0) && (timer_irq_o === 1'b0);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%b d=%h e=%b rdy=%b sw=%b tm=%b required 0 0 0 1 0 0",
               resp_v_o, resp_data_o, resp_err_o, cmd_ready_o, software_irq_o, timer_irq_o);
    end
    // Reset while a response is pending drops it.
    cmd_v_i = 1'b1; cmd_w_i = 1'b0; cmd_addr_i = 56'h0200_bff8; cmd_size_i = 2'd3;
    @(negedge clk);
    cmd_v_i = 1'b0;
    n_checks++;
    if (resp_v_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_resp: resp_v_o=%b required 1", resp_v_o);
    end
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    model_reset(cyc);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (resp_v_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_drop: resp_v_o=%b cmd_ready_o=%b required 0 1",
                 resp_v_o, cmd_ready_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mtime_idle();
    logic [63:0] rd, erd;
    logic        err, eerr;
    longint      acc;
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    model_reset(cyc);
    repeat (10) @(negedge clk);
    xact(1'b0, 32'h0200_bff8, 2'd3, 64'h0, rd, err, acc);
    model_access(1'b0, 32'h0200_bff8, 2'd3, 64'h0, acc, erd, eerr);
    n_checks++;
    if (rd !== erd || err !== eerr || timer_irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mtime_idle: data=%h err=%b tm=%b required %h %b 0",
               rd, err, timer_irq_o, erd, eerr);
    end
  endtask

  task automatic test_timer_irq();
    logic [63:0] rd, erd;
    logic        err, eerr;
    longint      acc;
    xact(1'b1, 32'h0200_bff8, 2'd3, 64'h0, rd, err, acc);
    model_access(1'b1, 32'h0200_bff8, 2'd3, 64'h0, acc, erd, eerr);
    xact(1'b1, 32'h0200_4000, 2'd3, 64'h20, rd, err, acc);
    model_access(1'b1, 32'h0200_4000, 2'd3, 64'h20, acc, erd, eerr);
    for (int i = 0; i < 300 && mtime_at(cyc) < 64'h24; i++) begin
      n_checks++;
      if (timer_irq_o !== exp_timer(cyc)) begin
        n_fail++;
        $display("FAIL timer_rise: tm=%b required %b at mtime %h",
                 timer_irq_o, exp_timer(cyc), mtime_at(cyc));
      end
      @(negedge clk);
    end
    n_checks++;
    if (timer_irq_o !== 1'b1) begin
      n_fail++; $display("FAIL timer_high: tm=%b required 1", timer_irq_o);
    end
    xact(1'b1, 32'h0200_4000, 2'd2, 64'hFFFF_FFFF, rd, err, acc);
    model_access(1'b1, 32'h0200_4000, 2'd2, 64'hFFFF_FFFF, acc, erd, eerr);
    n_checks++;
    if (timer_irq_o !== exp_timer(cyc) || err !== eerr) begin
      n_fail++;
      $display("FAIL timer_fall: tm=%b err=%b required %b %b",
               timer_irq_o, err, exp_timer(cyc), eerr);
    end
  endtask

  task automatic test_msip();
    logic [63:0] vals [4];
    logic [63:0] rd, erd;
    logic        err, eerr;
    longint      acc;
    vals = '{64'h1, 64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    foreach (vals[i]) begin
      xact(1'b1, 32'h0200_0000, 2'd3, vals[i], rd, err, acc);
      model_access(1'b1, 32'h0200_0000, 2'd3, vals[i], acc, erd, eerr);
      n_checks++;
      if (software_irq_o !== m_msip || rd !== erd || err !== eerr) begin
        n_fail++;
        $display("FAIL msip_store: sw=%b data=%h err=%b required %b %h %b",
                 software_irq_o, rd, err, m_msip, erd, eerr);
      end
      xact(1'b0, 32'h0200_0000, 2'd3, 64'h0, rd, err, acc);
      model_access(1'b0, 32'h0200_0000, 2'd3, 64'h0, acc, erd, eerr);
      n_checks++;
      if (rd !== erd || err !== eerr) begin
        n_fail++;
        $display("FAIL msip_load: data=%h err=%b required %h %b", rd, err, erd, eerr);
      end
    end
  endtask

  task automatic test_wrap_collision();
    logic [31:0] ad [5];
    logic [1:0]  sz [5];
    logic        wr [5];
    logic [63:0] dt [5];
    logic [63:0] rd, erd;
    logic        err, eerr;
    longint      acc;
    ad = '{32'h0200_bff8, 32'h0200_bff8, 32'h0200_bffc, 32'h0200_bffc, 32'h0200_bff8};
    sz = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd3};
    wr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    dt = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h1234_5678, 64'h0, 64'h0};
    foreach (ad[i]) begin
      xact(wr[i], ad[i], sz[i], dt[i], rd, err, acc);
      model_access(wr[i], ad[i], sz[i], dt[i], acc, erd, eerr);
      n_checks++;
      if (rd !== erd || err !== eerr) begin
        n_fail++;
        $display("FAIL wrap_%0d: data=%h err=%b required %h %b", i, rd, err, erd, eerr);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ad [6];
    logic [1:0]  sz [6];
    logic        wr [6];
    logic [63:0] rd, erd;
    logic        err, eerr;
    longint      acc;
    ad = '{32'h0200_0100, 32'h0200_4000, 32'h0200_4004, 32'h0200_4004, 32'h0200_bff8,
           32'h0200_0004};
    sz = '{2'd3, 2'd1, 2'd3, 2'd3, 2'd0, 2'd2};
    wr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    foreach (ad[i]) begin
      xact(wr[i], ad[i], sz[i], 64'h5555_AAAA_0000_0001, rd, err, acc);
      model_access(wr[i], ad[i], sz[i], 64'h5555_AAAA_0000_0001, acc, erd, eerr);
      n_checks++;
      if (rd !== 64'h0 || err !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_%0d: data=%h err=%b required 0 1", i, rd, err);
      end
    end
    xact(1'b0, 32'h0200_4000, 2'd3, 64'h0, rd, err, acc);
    model_access(1'b0, 32'h0200_4000, 2'd3, 64'h0, acc, erd, eerr);
    n_checks++;
    if (rd !== erd || err !== eerr || software_irq_o !== m_msip) begin
      n_fail++;
      $display("FAIL illegal_unchanged: cmp=%h sw=%b required %h %b",
               rd, software_irq_o, erd, m_msip);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    logic [31:0] a;
    logic [1:0]  s;
    logic        w;
    logic [63:0] d, rd, erd;
    logic        err, eerr;
    longint      acc;
    pool = '{32'h0200_0000, 32'h0200_4000, 32'h0200_4004, 32'h0200_bff8, 32'h0200_bffc,
             32'h0200_0008};
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? {8'h02, 24'($urandom)} : pool[$urandom_range(0, 5)];
      s = 2'($urandom_range(0, 3));
      w = 1'($urandom);
      d = {$urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xact(w, a, s, d, rd, err, acc);
      model_access(w, a, s, d, acc, erd, eerr);
      n_checks++;
      if (rd !== erd || err !== eerr || software_irq_o !== m_msip ||
          timer_irq_o !== exp_timer(cyc)) begin
        n_fail++;
        $display("FAIL random_%0d a=%h s=%0d w=%b: data=%h err=%b sw=%b tm=%b required %h %b %b %b",
                 i, a, s, w, rd, err, software_irq_o, timer_irq_o, erd, eerr, m_msip,
                 exp_timer(cyc));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] erd1, erd2;
    logic        eerr1, eerr2;
    longint      acc1, acc2;
    cmd_v_i = 1'b1; cmd_w_i = 1'b0; cmd_addr_i = 56'h0200_bff8; cmd_size_i = 2'd3;
    acc1 = cyc;
    model_access(1'b0, 32'h0200_bff8, 2'd3, 64'h0, acc1, erd1, eerr1);
    @(negedge clk);
    cmd_addr_i = 56'h0200_0000;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (resp_v_o !== 1'b1 || resp_data_o !== erd1 || resp_err_o !== eerr1 ||
          cmd_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d: v=%b data=%h err=%b rdy=%b required 1 %h %b 0",
                 i, resp_v_o, resp_data_o, resp_err_o, cmd_ready_o, erd1, eerr1);
      end
      @(negedge clk);
    end
    resp_yumi_i = 1'b1;
    @(negedge clk);
    resp_yumi_i = 1'b0;
    acc2 = cyc;
    model_access(1'b0, 32'h0200_0000, 2'd3, 64'h0, acc2, erd2, eerr2);
    n_checks++;
    if (cmd_ready_o !== 1'b1 || resp_v_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready: rdy=%b v=%b required 1 0", cmd_ready_o, resp_v_o);
    end
    @(negedge clk);
    cmd_v_i = 1'b0;
    n_checks++;
    if (resp_v_o !== 1'b1 || resp_data_o !== erd2 || resp_err_o !== eerr2) begin
      n_fail++;
      $display("FAIL b2b_second: v=%b data=%h err=%b required 1 %h %b",
               resp_v_o, resp_data_o, resp_err_o, erd2, eerr2);
    end
    resp_yumi_i = 1'b1;
    @(negedge clk);
    resp_yumi_i = 1'b0;
  endtask

`ifdef BP_CLINT_PRESCALE_EN
  task automatic test_prescale();
    logic [63:0] rd1, rd2, erd;
    logic        err, eerr;
    longint      acc1, acc2;
    xact(1'b0, 32'h0200_bff8, 2'd3, 64'h0, rd1, err, acc1);
    model_access(1'b0, 32'h0200_bff8, 2'd3, 64'h0, acc1, erd, eerr);
    while (cyc < acc1 + 40) @(negedge clk);
    xact(1'b0, 32'h0200_bff8, 2'd3, 64'h0, rd2, err, acc2);
    model_access(1'b0, 32'h0200_bff8, 2'd3, 64'h0, acc2, erd, eerr);
    n_checks++;
    if (rd2 - rd1 !== 64'd10 || rd2 !== erd) begin
      n_fail++;
      $display("FAIL prescale: advance=%0d value=%h required 10 %h", rd2 - rd1, rd2, erd);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_mtime_idle();
    test_timer_irq();
    test_msip();
    test_wrap_collision();
    test_illegal();
    test_random();
    test_back_to_back();
`ifdef BP_CLINT_PRESCALE_EN
    test_prescale();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
